// File: rtl/mem_lsu.sv
// MEM stage with a multi-cycle load/store unit: ALU results pass straight through,
// loads/stores run one req/ack bus transaction and stall the pipeline meanwhile.
module mem_lsu #(
    parameter int TIMEOUT = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  wd_i,
    input  logic        wreg_i,
    input  logic [31:0] wdata_i,
    input  logic [31:0] hi_i,
    input  logic [31:0] lo_i,
    input  logic        whilo_i,
    input  logic [7:0]  aluop_i,
    input  logic [31:0] mem_addr_i,
    input  logic [31:0] reg2_i,
    input  logic [5:0]  stall_i,
    input  logic [31:0] bus_rdata_i,
    input  logic        bus_ack_i,
    output logic        bus_req_o,
    output logic        bus_we_o,
    output logic [31:0] bus_addr_o,
    output logic [3:0]  bus_sel_o,
    output logic [31:0] bus_wdata_o,
    output logic [4:0]  mem_wd_o,
    output logic        mem_wreg_o,
    output logic [31:0] mem_wdata_o,
    output logic [31:0] mem_hi_o,
    output logic [31:0] mem_lo_o,
    output logic        mem_whilo_o,
    output logic        stallreq_o,
    output logic        misalign_o,
    output logic        bus_err_o
);
    localparam logic [7:0] OP_LB = 8'hE0, OP_LH = 8'hE1, OP_LW = 8'hE3, OP_LBU = 8'hE4;
    localparam logic [7:0] OP_LHU = 8'hE5, OP_SB = 8'hE8, OP_SH = 8'hE9, OP_SW = 8'hEB;

    typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

    state_t      state_q, state_d;
    logic        bus_req_q, bus_req_d, bus_we_q, bus_we_d, err_q, err_d;
    logic [31:0] addr_q, addr_d, wdata_q, wdata_d, rdata_q, rdata_d, cnt_q, cnt_d;
    logic [3:0]  sel_q, sel_d;
    logic [7:0]  op_q, op_d;
    logic [1:0]  off_q, off_d;

    logic        is_mem, misal;
    logic [3:0]  sel_c;
    logic [31:0] wdata_c, load_data;
    logic [7:0]  byte_c;
    logic [15:0] half_c;
    logic        unused_stall;

    assign unused_stall = ^{stall_i[5], stall_i[3:0]};

    always_comb begin
        is_mem  = 1'b0;
        misal   = 1'b0;
        sel_c   = 4'b0000;
        wdata_c = reg2_i;
        case (aluop_i)
            OP_LB, OP_LBU, OP_SB: begin
                is_mem  = 1'b1;
                sel_c   = 4'b1000 >> mem_addr_i[1:0];
                wdata_c = {4{reg2_i[7:0]}};
            end
            OP_LH, OP_LHU, OP_SH: begin
                is_mem  = 1'b1;
                misal   = mem_addr_i[0];
                sel_c   = mem_addr_i[1] ? 4'b0011 : 4'b1100;
                wdata_c = {2{reg2_i[15:0]}};
            end
            OP_LW, OP_SW: begin
                is_mem = 1'b1;
                misal  = |mem_addr_i[1:0];
                sel_c  = 4'b1111;
            end
            default: ;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        bus_req_d = bus_req_q;
        bus_we_d  = bus_we_q;
        err_d     = err_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        rdata_d   = rdata_q;
        cnt_d     = cnt_q;
        sel_d     = sel_q;
        op_d      = op_q;
        off_d     = off_q;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                err_d = 1'b0;
                if (is_mem && !misal) begin
                    state_d   = REQ;
                    bus_req_d = 1'b1;
                    bus_we_d  = aluop_i[3];
                    addr_d    = {mem_addr_i[31:2], 2'b00};
                    sel_d     = sel_c;
                    wdata_d   = wdata_c;
                    op_d      = aluop_i;
                    off_d     = mem_addr_i[1:0];
                end
            end
            REQ: begin
                if (bus_ack_i) begin
                    rdata_d   = bus_rdata_i;
                    bus_req_d = 1'b0;
                    state_d   = DONE;
                end else if (TIMEOUT != 0 && cnt_q == 32'(TIMEOUT - 1)) begin
                    bus_req_d = 1'b0;
                    err_d     = 1'b1;
                    state_d   = DONE;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            DONE: begin
                // ex_mem delivers the next instruction on the same edge we leave DONE
                if (!stall_i[4]) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            bus_req_q <= 1'b0;
            bus_we_q  <= 1'b0;
            err_q     <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            rdata_q   <= '0;
            cnt_q     <= '0;
            sel_q     <= '0;
            op_q      <= '0;
            off_q     <= '0;
        end else begin
            state_q   <= state_d;
            bus_req_q <= bus_req_d;
            bus_we_q  <= bus_we_d;
            err_q     <= err_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            rdata_q   <= rdata_d;
            cnt_q     <= cnt_d;
            sel_q     <= sel_d;
            op_q      <= op_d;
            off_q     <= off_d;
        end
    end

    // Big-endian lane pick: offset 0 is the most significant byte
    always_comb begin
        case (off_q)
            2'd0:    byte_c = rdata_q[31:24];
            2'd1:    byte_c = rdata_q[23:16];
            2'd2:    byte_c = rdata_q[15:8];
            default: byte_c = rdata_q[7:0];
        endcase
        half_c = off_q[1] ? rdata_q[15:0] : rdata_q[31:16];
        case (op_q)
            OP_LB:   load_data = {{24{byte_c[7]}}, byte_c};
            OP_LBU:  load_data = {24'd0, byte_c};
            OP_LH:   load_data = {{16{half_c[15]}}, half_c};
            OP_LHU:  load_data = {16'd0, half_c};
            default: load_data = rdata_q;
        endcase
    end

    always_comb begin
        mem_wd_o    = wd_i;
        mem_wreg_o  = wreg_i;
        mem_wdata_o = wdata_i;
        mem_hi_o    = hi_i;
        mem_lo_o    = lo_i;
        mem_whilo_o = whilo_i;
        stallreq_o  = 1'b0;
        misalign_o  = 1'b0;
        bus_err_o   = 1'b0;
        bus_req_o   = bus_req_q;
        bus_we_o    = bus_we_q;
        bus_addr_o  = addr_q;
        bus_sel_o   = sel_q;
        bus_wdata_o = wdata_q;
        case (state_q)
            IDLE: begin
                if (is_mem) begin
                    mem_wreg_o = 1'b0;
                    misalign_o = misal;
                    stallreq_o = !misal;
                end
            end
            REQ: begin
                mem_wreg_o = 1'b0;
                stallreq_o = 1'b1;
            end
            DONE: begin
                bus_err_o = err_q;
                if (op_q[3] || err_q) mem_wreg_o = 1'b0;
                else mem_wdata_o = load_data;
            end
            default: ;
        endcase
        if (rst) begin
            mem_wd_o    = '0;
            mem_wreg_o  = 1'b0;
            mem_wdata_o = '0;
            mem_hi_o    = '0;
            mem_lo_o    = '0;
            mem_whilo_o = 1'b0;
            stallreq_o  = 1'b0;
            misalign_o  = 1'b0;
            bus_err_o   = 1'b0;
            bus_req_o   = 1'b0;
            bus_we_o    = 1'b0;
            bus_addr_o  = '0;
            bus_sel_o   = '0;
            bus_wdata_o = '0;
        end
    end
endmodule

// File: tb/tb_mem_lsu.sv
// Randomized scoreboard bench for mem_lsu: byte-level reference memory, a bus
// responder with its own word memory, and a monitor checking every retirement.
module tb_mem_lsu;
    localparam int TIMEOUT = 4;

    logic        clk = 1'b0, rst;
    logic [4:0]  wd_i;
    logic        wreg_i, whilo_i, bus_ack_i;
    logic [31:0] wdata_i, hi_i, lo_i, mem_addr_i, reg2_i, bus_rdata_i;
    logic [7:0]  aluop_i;
    logic [5:0]  stall_i;
    logic        bus_req_o, bus_we_o, mem_wreg_o, mem_whilo_o, stallreq_o, misalign_o, bus_err_o;
    logic [31:0] bus_addr_o, bus_wdata_o, mem_wdata_o, mem_hi_o, mem_lo_o;
    logic [3:0]  bus_sel_o;
    logic [4:0]  mem_wd_o;

    mem_lsu #(.TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst), .wd_i(wd_i), .wreg_i(wreg_i), .wdata_i(wdata_i),
        .hi_i(hi_i), .lo_i(lo_i), .whilo_i(whilo_i), .aluop_i(aluop_i),
        .mem_addr_i(mem_addr_i), .reg2_i(reg2_i), .stall_i(stall_i),
        .bus_rdata_i(bus_rdata_i), .bus_ack_i(bus_ack_i), .bus_req_o(bus_req_o),
        .bus_we_o(bus_we_o), .bus_addr_o(bus_addr_o), .bus_sel_o(bus_sel_o),
        .bus_wdata_o(bus_wdata_o), .mem_wd_o(mem_wd_o), .mem_wreg_o(mem_wreg_o),
        .mem_wdata_o(mem_wdata_o), .mem_hi_o(mem_hi_o), .mem_lo_o(mem_lo_o),
        .mem_whilo_o(mem_whilo_o), .stallreq_o(stallreq_o), .misalign_o(misalign_o),
        .bus_err_o(bus_err_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  wd;
        logic        wreg;
        logic [31:0] wdata, hi, lo;
        logic        whilo, mis, err, chk_wdata;
    } exp_t;
    typedef struct {
        logic [31:0] addr, wdata;
        logic [3:0]  sel;
        logic        we;
    } bus_t;

    exp_t        exp_q[$];
    bus_t        bus_q[$];
    logic [7:0]  refmem [0:1023];
    logic [31:0] bmem [0:255];
    int          checks = 0, errors = 0;
    int          force_delay = -1, last_delay = 0;
    bit          noack = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h, want %h (t=%0t)", name, act, req, $time);
        end
    endtask

    function automatic int op_size(input logic [7:0] op);
        case (op)
            8'hE0, 8'hE4, 8'hE8: return 1;
            8'hE1, 8'hE5, 8'hE9: return 2;
            8'hE3, 8'hEB:        return 4;
            default:             return 0;
        endcase
    endfunction

    task automatic set_word(input int a, input logic [31:0] w);
        bmem[a / 4] = w;
        for (int j = 0; j < 4; j++) refmem[a + j] = 8'(w >> (8 * (3 - j)));
    endtask

    // Monitor: compares whenever the stage presents a result to mem_wb
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst && !stallreq_o && exp_q.size() > 0) begin
                e = exp_q[0];
                chk("mem_wd", {27'd0, mem_wd_o}, {27'd0, e.wd});
                chk("mem_wreg", {31'd0, mem_wreg_o}, {31'd0, e.wreg});
                if (e.chk_wdata) chk("mem_wdata", mem_wdata_o, e.wdata);
                chk("mem_hi", mem_hi_o, e.hi);
                chk("mem_lo", mem_lo_o, e.lo);
                chk("mem_whilo", {31'd0, mem_whilo_o}, {31'd0, e.whilo});
                chk("misalign", {31'd0, misalign_o}, {31'd0, e.mis});
                chk("bus_err", {31'd0, bus_err_o}, {31'd0, e.err});
                if (!stall_i[4]) void'(exp_q.pop_front());
            end
        end
    end

    // Bus responder with its own word memory
    initial begin
        bit busy = 0, acked = 0;
        int wn = 0, dly = 0;
        bus_t b;
        bus_ack_i = 1'b0;
        bus_rdata_i = '0;
        forever begin
            @(negedge clk);
            bus_ack_i = 1'b0;
            if (rst) begin
                busy = 0;
                acked = 0;
                bus_ack_i = 1'($urandom_range(0, 1));
                continue;
            end
            if (acked) begin
                acked = 0;
                chk("req_drop", {31'd0, bus_req_o}, 32'd0);
            end else if (bus_req_o) begin
                if (!busy) begin
                    busy = 1;
                    wn = 0;
                    if (bus_q.size() == 0) begin
                        chk("bus_unexpected", {31'd0, bus_req_o}, 32'd0);
                    end else begin
                        b = bus_q.pop_front();
                        chk("bus_addr", bus_addr_o, b.addr);
                        chk("bus_sel", {28'd0, bus_sel_o}, {28'd0, b.sel});
                        chk("bus_we", {31'd0, bus_we_o}, {31'd0, b.we});
                        if (b.we) chk("bus_wdata", bus_wdata_o, b.wdata);
                    end
                    dly = (force_delay >= 0) ? force_delay : $urandom_range(0, 2);
                    last_delay = dly;
                end else begin
                    wn++;
                end
                bus_rdata_i = $urandom;
                if (!noack && wn == dly) begin
                    bus_ack_i = 1'b1;
                    if (bus_we_o) begin
                        for (int k = 0; k < 4; k++)
                            if (bus_sel_o[3-k]) bmem[bus_addr_o[9:2]][31-8*k -: 8] = bus_wdata_o[31-8*k -: 8];
                    end else begin
                        bus_rdata_i = bmem[bus_addr_o[9:2]];
                    end
                    busy = 0;
                    acked = 1;
                end
            end else if (busy) begin
                busy = 0;
                chk("req_len", 32'(wn + 1), 32'(TIMEOUT));
            end
        end
    end

    // Issue one instruction from posedge+1, return at posedge+1 after it retires
    task automatic issue(input logic [7:0] op, input logic [31:0] addr, input logic [31:0] reg2,
                         input logic [4:0] wd, input logic [31:0] wdata, input logic wreg,
                         input int delay, input bit na, input int hold);
        exp_t e;
        bus_t b;
        int sz, off, sc, cyc, exp_sc, h;
        logic [31:0] v;
        bit is_bus;
        sz = op_size(op);
        off = int'(addr[1:0]);
        e.wd = wd; e.wreg = wreg; e.wdata = wdata;
        e.hi = $urandom; e.lo = $urandom; e.whilo = 1'($urandom_range(0, 1));
        e.mis = 1'b0; e.err = 1'b0; e.chk_wdata = 1'b1;
        is_bus = 0;
        if (sz != 0 && (addr % sz) != 0) begin
            e.mis = 1'b1;
            e.wreg = 1'b0;
        end else if (sz != 0) begin
            is_bus = 1;
            e.wreg = 1'b0;
            b.addr = addr & ~32'd3;
            b.we = op[3];
            b.sel = '0;
            b.wdata = '0;
            for (int k = 0; k < 4; k++) begin
                if (k >= off && k < off + sz) b.sel[3-k] = 1'b1;
                b.wdata[31-8*k -: 8] = 8'(reg2 >> (8 * (sz - 1 - (k % sz))));
            end
            bus_q.push_back(b);
            if (na) begin
                e.err = 1'b1;
                e.chk_wdata = 1'b0;
            end else if (op[3]) begin
                for (int j = 0; j < sz; j++) refmem[addr[9:0] + j] = 8'(reg2 >> (8 * (sz - 1 - j)));
            end else begin
                v = 0;
                for (int j = 0; j < sz; j++) v = (v << 8) | 32'(refmem[addr[9:0] + j]);
                if (op == 8'hE0 && v[7]) v = v | 32'hFFFFFF00;
                if (op == 8'hE1 && v[15]) v = v | 32'hFFFF0000;
                e.wdata = v;
                e.wreg = wreg;
            end
        end
        exp_q.push_back(e);
        force_delay = delay;
        noack = na;
        aluop_i = op; mem_addr_i = addr; reg2_i = reg2; wd_i = wd; wdata_i = wdata; wreg_i = wreg;
        hi_i = e.hi; lo_i = e.lo; whilo_i = e.whilo;
        h = is_bus ? hold : 0;
        stall_i = (h > 0) ? 6'b010000 : 6'b000000;
        sc = 0;
        cyc = 0;
        forever begin
            @(negedge clk);
            if (cyc == 0) chk("stall_start", {31'd0, stallreq_o}, {31'd0, is_bus});
            cyc++;
            if (cyc > 60) begin
                checks++;
                errors++;
                $display("FAIL instr_timeout: op %h never retired", op);
                break;
            end
            if (stallreq_o) begin
                sc++;
            end else if (stall_i[4]) begin
                h--;
                @(posedge clk); #1;
                if (h <= 0) stall_i = 6'b000000;
            end else begin
                break;
            end
        end
        exp_sc = !is_bus ? 0 : (na ? TIMEOUT + 1 : ((delay >= 0 ? delay : last_delay) + 2));
        chk("stall_len", 32'(sc), 32'(exp_sc));
        @(posedge clk); #1;
        chk("retired", 32'(exp_q.size()), 32'd0);
        exp_q.delete();
        noack = 1'b0;
    endtask

    initial begin
        logic [7:0] ops[8] = '{8'hE0, 8'hE1, 8'hE3, 8'hE4, 8'hE5, 8'hE8, 8'hE9, 8'hEB};
        logic [7:0] op;
        logic [31:0] a;
        int sz;
        for (int i = 0; i < 256; i++) set_word(i * 4, $urandom);
        rst = 1'b1;
        stall_i = '0;
        aluop_i = 8'hE3; mem_addr_i = 32'h40; reg2_i = $urandom; wd_i = 5'd7; wreg_i = 1'b1;
        wdata_i = $urandom; hi_i = $urandom; lo_i = $urandom; whilo_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rst_outs", {31'd0, |{bus_req_o, bus_we_o, bus_addr_o, bus_sel_o, bus_wdata_o, mem_wd_o,
                mem_wreg_o, mem_wdata_o, mem_hi_o, mem_lo_o, mem_whilo_o, stallreq_o, misalign_o, bus_err_o}}, 32'd0);
        end
        @(posedge clk); #1;
        rst = 1'b0;

        issue(8'h20, 32'h0, 32'h0, 5'd3, 32'h12345678, 1'b1, -1, 0, 0);
        set_word(32'h100, 32'h11F03344);
        issue(8'hE0, 32'h101, 32'h0, 5'd4, 32'h0, 1'b1, 1, 0, 0);
        set_word(32'h100, 32'hAAAA8001);
        issue(8'hE5, 32'h102, 32'h0, 5'd5, 32'h0, 1'b1, 0, 0, 0);
        issue(8'hEB, 32'h203, 32'hDEADBEEF, 5'd6, 32'h9, 1'b1, -1, 0, 0);
        issue(8'hE3, 32'h40, 32'h0, 5'd8, 32'h0, 1'b1, -1, 1, 0);
        issue(8'hE8, 32'h3, 32'h000000A5, 5'd9, 32'h0, 1'b1, -1, 0, 2);
        issue(8'hE0, 32'h3, 32'h0, 5'd10, 32'h0, 1'b1, -1, 0, 0);

        for (int n = 0; n < 150; n++) begin
            if ($urandom_range(0, 9) < 2) begin
                do op = 8'($urandom_range(0, 255)); while (op_size(op) != 0);
            end else begin
                op = ops[$urandom_range(0, 7)];
            end
            sz = op_size(op);
            a = 32'($urandom_range(0, 1023));
            if (sz != 0 && $urandom_range(0, 3) != 0) a = a & ~32'(sz - 1);
            issue(op, a, $urandom, 5'($urandom_range(0, 31)), $urandom, 1'($urandom_range(0, 1)),
                  -1, ($urandom_range(0, 14) == 0), $urandom_range(0, 2));
        end

        // Reset arriving while a request is outstanding
        begin
            bus_t b;
            b.addr = 32'h80; b.sel = 4'hF; b.we = 1'b0; b.wdata = '0;
            bus_q.push_back(b);
        end
        noack = 1'b1;
        aluop_i = 8'hE3; mem_addr_i = 32'h80; stall_i = '0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("req_stall", {31'd0, stallreq_o}, 32'd1);
        end
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        chk("rst_mid_req", {31'd0, bus_req_o | stallreq_o | mem_wreg_o}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        noack = 1'b0;
        aluop_i = 8'h20; wdata_i = 32'h55; wreg_i = 1'b1;
        @(negedge clk);
        chk("post_rst_req", {31'd0, bus_req_o}, 32'd0);
        chk("post_rst_stall", {31'd0, stallreq_o}, 32'd0);
        chk("post_rst_wdata", mem_wdata_o, 32'h55);
        chk("post_rst_wreg", {31'd0, mem_wreg_o}, 32'd1);
        @(posedge clk); #1;
        chk("bus_q_empty", 32'(bus_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end
endmodule
